// File: rtl/receptor_vga_sincronia.sv
// VGA sync receiver: rebuilds pixel coordinates from active-low H/V syncs and
// tracks timing lock by measuring line length and lines per frame.
module receptor_vga_sincronia #(
  parameter int unsigned H_TOTAL       = 800,
  parameter int unsigned H_VISIBLE     = 640,
  parameter int unsigned H_SYNC_INICIO = 656,
  parameter int unsigned V_TOTAL       = 525,
  parameter int unsigned V_VISIBLE     = 480,
  parameter int unsigned V_SYNC_INICIO = 490
) (
  input  logic       clk25,
  input  logic       botonRST,
  input  logic       H_SYNC,
  input  logic       V_SYNC,
  output logic [9:0] cuentaX,
  output logic [9:0] cuentaY,
  output logic       visible,
  output logic       enganchado,
  output logic       cuadroNuevo,
  output logic       errorSincronia
);

  localparam logic [9:0] SAT   = '1;
  localparam logic [9:0] HT    = 10'(H_TOTAL);
  localparam logic [9:0] HT_M1 = 10'(H_TOTAL - 1);
  localparam logic [9:0] HV    = 10'(H_VISIBLE);
  localparam logic [9:0] HS    = 10'(H_SYNC_INICIO);
  localparam logic [9:0] VT    = 10'(V_TOTAL);
  localparam logic [9:0] VT_M1 = 10'(V_TOTAL - 1);
  localparam logic [9:0] VV    = 10'(V_VISIBLE);
  localparam logic [9:0] VS    = 10'(V_SYNC_INICIO);

  typedef enum logic [1:0] {BUSCANDO, MIDIENDO, ENGANCHADO} estado_t;

  estado_t    r_estado, w_estado_d;
  logic       r_hq, r_vq;
  logic [9:0] r_x, r_y, r_periodo, r_lineas;
  logic       r_malo, r_primera, r_cuadro, r_error;

  logic       w_hfall, w_vfall, w_xwrap;
  logic [9:0] w_x_d, w_y_d, w_periodo_d, w_lineas_d;
  logic       w_perdida, w_linea_ok, w_cuadro_ok, w_malo_ahora;
  logic       w_malo_d, w_primera_d, w_cuadro_d, w_error_d;

  assign w_hfall = ~H_SYNC & r_hq;
  assign w_vfall = ~V_SYNC & r_vq;
  assign w_xwrap = ~w_hfall & (r_x == HT_M1);

  always_comb begin
    w_x_d = r_x + 10'd1;
    if (w_hfall)      w_x_d = HS;
    else if (w_xwrap) w_x_d = '0;

    w_y_d = r_y;
    if (w_vfall)      w_y_d = VS;
    else if (w_xwrap) w_y_d = (r_y == VT_M1) ? '0 : r_y + 10'd1;

    w_periodo_d = (r_periodo == SAT) ? SAT : r_periodo + 10'd1;
    if (w_hfall) w_periodo_d = 10'd1;

    // An H fall on the same edge as a V fall is the first line of the new frame.
    w_lineas_d = r_lineas;
    if (w_vfall)                         w_lineas_d = {9'd0, w_hfall};
    else if (w_hfall && r_lineas != SAT) w_lineas_d = r_lineas + 10'd1;
  end

  assign w_perdida    = (w_periodo_d == SAT) | (w_lineas_d == SAT);
  assign w_linea_ok   = (r_periodo == HT);
  assign w_cuadro_ok  = (r_lineas == VT);
  assign w_malo_ahora = r_malo | (w_hfall & ~r_primera & ~w_linea_ok);

  always_comb begin
    w_estado_d  = r_estado;
    w_malo_d    = r_malo;
    w_primera_d = r_primera;
    w_cuadro_d  = 1'b0;
    w_error_d   = 1'b0;
    case (r_estado)
      BUSCANDO: begin
        if (w_vfall) begin
          w_estado_d  = MIDIENDO;
          w_malo_d    = 1'b0;
          w_primera_d = 1'b1;
        end
      end
      MIDIENDO: begin
        if (w_perdida) begin
          w_estado_d = BUSCANDO;
        end else if (w_vfall) begin
          if (w_cuadro_ok && !w_malo_ahora) begin
            w_estado_d = ENGANCHADO;
            w_cuadro_d = 1'b1;
          end else begin
            w_malo_d    = 1'b0;
            w_primera_d = 1'b1;
          end
        end else if (w_hfall) begin
          w_primera_d = 1'b0;
          w_malo_d    = w_malo_ahora;
        end
      end
      ENGANCHADO: begin
        if ((w_hfall && !w_linea_ok) || (w_vfall && !w_cuadro_ok) || w_perdida) begin
          w_estado_d = BUSCANDO;
          w_error_d  = 1'b1;
        end else if (w_vfall) begin
          w_cuadro_d = 1'b1;
        end
      end
      default: w_estado_d = BUSCANDO;
    endcase
  end

  always_ff @(posedge clk25) begin
    if (botonRST) begin
      r_estado  <= BUSCANDO;
      r_hq      <= 1'b1;
      r_vq      <= 1'b1;
      r_x       <= '0;
      r_y       <= '0;
      r_periodo <= '0;
      r_lineas  <= '0;
      r_malo    <= 1'b0;
      r_primera <= 1'b0;
      r_cuadro  <= 1'b0;
      r_error   <= 1'b0;
    end else begin
      r_estado  <= w_estado_d;
      r_hq      <= H_SYNC;
      r_vq      <= V_SYNC;
      r_x       <= w_x_d;
      r_y       <= w_y_d;
      r_periodo <= w_periodo_d;
      r_lineas  <= w_lineas_d;
      r_malo    <= w_malo_d;
      r_primera <= w_primera_d;
      r_cuadro  <= w_cuadro_d;
      r_error   <= w_error_d;
    end
  end

  assign cuentaX        = r_x;
  assign cuentaY        = r_y;
  assign enganchado     = (r_estado == ENGANCHADO);
  assign visible        = enganchado && (r_x < HV) && (r_y < VV);
  assign cuadroNuevo    = r_cuadro;
  assign errorSincronia = r_error;

endmodule

// File: tb/tb_receptor_vga_sincronia.sv
// Bench for receptor_vga_sincronia on a reduced raster (40x20) so that several
// full frames, error cases and the 1023-cycle loss timeout fit in a short run.
module tb_receptor_vga_sincronia;

  localparam int HT = 40;
  localparam int HV = 32;
  localparam int HS = 34;
  localparam int VT = 20;
  localparam int VV = 16;
  localparam int VS = 17;

  logic       clk25 = 1'b0;
  logic       botonRST = 1'b1;
  logic       H_SYNC = 1'b1;
  logic       V_SYNC = 1'b1;
  logic [9:0] cuentaX, cuentaY;
  logic       visible, enganchado, cuadroNuevo, errorSincronia;

  receptor_vga_sincronia #(
    .H_TOTAL(HT), .H_VISIBLE(HV), .H_SYNC_INICIO(HS),
    .V_TOTAL(VT), .V_VISIBLE(VV), .V_SYNC_INICIO(VS)
  ) dut (
    .clk25(clk25), .botonRST(botonRST), .H_SYNC(H_SYNC), .V_SYNC(V_SYNC),
    .cuentaX(cuentaX), .cuentaY(cuentaY), .visible(visible),
    .enganchado(enganchado), .cuadroNuevo(cuadroNuevo),
    .errorSincronia(errorSincronia)
  );

  always #5 clk25 = ~clk25;

  typedef struct packed {
    logic       chk;
    logic [9:0] x;
    logic [9:0] y;
    logic       vis, eng, cn, err;
  } exp_t;

  typedef struct packed {
    logic       rst, h, v;
    logic [9:0] x, y;
    logic       eng, cn, err;
  } vec_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   cycles = 0;
  int   vis_cnt = 0;
  bit   cnt_vis = 0;

  // Sync generator state: position next driven, one-shot long line, frame height,
  // column at which V_SYNC toggles, and forced-high sync lines.
  int gx = 0, gy = 0, extra = 0, vt_cur = VT, vfx = 0;
  bit hold = 0, skew = 0, lk = 0;

  task automatic step_raw(input logic rst, input logic h, input logic v,
                          input exp_t e, input string tag);
    exp_t        q;
    logic [23:0] act, req, m;
    botonRST = rst;
    H_SYNC   = h;
    V_SYNC   = v;
    sb.push_back(e);
    @(posedge clk25);
    #1;
    cycles++;
    if (cnt_vis && visible) vis_cnt++;
    q   = sb.pop_front();
    act = {cuentaX, cuentaY, visible, enganchado, cuadroNuevo, errorSincronia};
    req = {q.x, q.y, q.vis, q.eng, q.cn, q.err};
    m   = q.chk ? 24'hFF_FFFF : 24'h00_0007;
    checks++;
    if ((act & m) != (req & m)) begin
      errors++;
      $display("FAIL %s cycle %0d: got X=%0d Y=%0d vis=%b eng=%b cn=%b err=%b, expected X=%0d Y=%0d vis=%b eng=%b cn=%b err=%b (xy checked=%b)",
               tag, cycles, cuentaX, cuentaY, visible, enganchado, cuadroNuevo,
               errorSincronia, q.x, q.y, q.vis, q.eng, q.cn, q.err, q.chk);
    end
    if (cycles > 60000) begin
      $display("FAIL cycle_budget: got %0d cycles, required at most 60000", cycles);
      $fatal(1);
    end
  endtask

  task automatic step(input logic rst, input bit e_cn, input bit e_err,
                      input bit lk_after, input string tag);
    exp_t e;
    logic h, v;
    h = hold ? 1'b1 : !(gx >= HS && gx < HS + 4);
    v = hold ? 1'b1 : !((gy == VS && gx >= vfx) || (gy == VS + 1) || (gy == VS + 2 && gx < vfx));
    e = '0;
    if (rst) begin
      e.chk = 1'b1;
    end else begin
      e.chk = lk_after && !skew;
      e.x   = 10'(gx);
      e.y   = 10'(gy);
      e.vis = lk_after && gx < HV && gy < VV;
      e.eng = lk_after;
      e.cn  = e_cn;
      e.err = e_err;
    end
    step_raw(rst, h, v, e, tag);
    lk = rst ? 1'b0 : lk_after;
    if (!lk) skew = 0;
    if (gx == HT - 1 + extra) begin
      gx    = 0;
      extra = 0;
      if (gy == vt_cur - 1) begin
        gy     = 0;
        vt_cur = VT;
      end else begin
        gy = gy + 1;
      end
    end else begin
      gx = gx + 1;
    end
  endtask

  task automatic run_until_pos(input int tx, input int ty, input string tag);
    while (!(gx == tx && gy == ty)) step(1'b0, 1'b0, 1'b0, lk, tag);
  endtask

  task automatic run_until_vfall(input bit lk_new, input bit cn, input bit err,
                                 input string tag);
    while (!(gx == vfx && gy == VS)) step(1'b0, 1'b0, 1'b0, lk, tag);
    step(1'b0, cn, err, lk_new, tag);
  endtask

  task automatic relock(input string tag);
    run_until_vfall(1'b0, 1'b0, 1'b0, tag);
    run_until_vfall(1'b1, 1'b1, 1'b0, tag);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got no finish after 100000 cycles, required finish");
    $fatal(1);
  end

  initial begin
    vec_t tbl[15];
    exp_t e;
    // rst h v | X Y | eng cn err
    tbl[0]  = '{1'b1, 1'b1, 1'b1, 10'd0,  10'd0,  1'b0, 1'b0, 1'b0};
    tbl[1]  = '{1'b0, 1'b1, 1'b1, 10'd1,  10'd0,  1'b0, 1'b0, 1'b0};
    tbl[2]  = '{1'b0, 1'b0, 1'b1, 10'd34, 10'd0,  1'b0, 1'b0, 1'b0};
    tbl[3]  = '{1'b0, 1'b0, 1'b1, 10'd35, 10'd0,  1'b0, 1'b0, 1'b0};
    tbl[4]  = '{1'b0, 1'b1, 1'b1, 10'd36, 10'd0,  1'b0, 1'b0, 1'b0};
    tbl[5]  = '{1'b0, 1'b0, 1'b1, 10'd34, 10'd0,  1'b0, 1'b0, 1'b0};
    tbl[6]  = '{1'b0, 1'b0, 1'b0, 10'd35, 10'd17, 1'b0, 1'b0, 1'b0};
    tbl[7]  = '{1'b0, 1'b1, 1'b0, 10'd36, 10'd17, 1'b0, 1'b0, 1'b0};
    tbl[8]  = '{1'b0, 1'b1, 1'b1, 10'd37, 10'd17, 1'b0, 1'b0, 1'b0};
    tbl[9]  = '{1'b0, 1'b0, 1'b0, 10'd34, 10'd17, 1'b0, 1'b0, 1'b0};
    tbl[10] = '{1'b0, 1'b1, 1'b1, 10'd35, 10'd17, 1'b0, 1'b0, 1'b0};
    tbl[11] = '{1'b1, 1'b0, 1'b0, 10'd0,  10'd0,  1'b0, 1'b0, 1'b0};
    tbl[12] = '{1'b0, 1'b0, 1'b0, 10'd34, 10'd17, 1'b0, 1'b0, 1'b0};
    tbl[13] = '{1'b1, 1'b1, 1'b1, 10'd0,  10'd0,  1'b0, 1'b0, 1'b0};
    tbl[14] = '{1'b0, 1'b1, 1'b1, 10'd1,  10'd0,  1'b0, 1'b0, 1'b0};

    for (int i = 0; i < 15; i++) begin
      e     = '0;
      e.chk = 1'b1;
      e.x   = tbl[i].x;
      e.y   = tbl[i].y;
      e.eng = tbl[i].eng;
      e.cn  = tbl[i].cn;
      e.err = tbl[i].err;
      step_raw(tbl[i].rst, tbl[i].h, tbl[i].v, e, $sformatf("vector%0d", i));
    end

    // Nominal stream from reset: lock on the second V fall.
    e     = '0;
    e.chk = 1'b1;
    step_raw(1'b1, 1'b1, 1'b1, e, "reset_state");
    lk = 0;
    relock("nominal_lock");

    cnt_vis = 1;
    run_until_vfall(1'b1, 1'b1, 1'b0, "nominal_frame");
    cnt_vis = 0;
    checks++;
    if (vis_cnt != HV * VV) begin
      errors++;
      $display("FAIL visible_count: got %0d, expected %0d", vis_cnt, HV * VV);
    end

    // One line one clock too long.
    run_until_pos(0, 3, "long_line_pre");
    extra = 1;
    skew  = 1;
    run_until_pos(HS, 4, "long_line");
    step(1'b0, 1'b0, 1'b1, 1'b0, "long_line_error");
    relock("long_line_relock");

    // Frame one line short.
    vt_cur = VT - 1;
    skew   = 1;
    run_until_vfall(1'b0, 1'b0, 1'b1, "short_frame_error");
    relock("short_frame_relock");

    // Loss of signal: syncs held high after an H fall.
    run_until_pos(HS, 3, "loss_pre");
    step(1'b0, 1'b0, 1'b0, 1'b1, "loss_last_hfall");
    hold = 1;
    for (int k = 1; k < 1022; k++) step(1'b0, 1'b0, 1'b0, 1'b1, "loss_wait");
    step(1'b0, 1'b0, 1'b1, 1'b0, "loss_error");
    run_until_pos(0, 0, "loss_idle");
    hold = 0;
    relock("loss_relock");

    // Reset mid-frame while locked.
    run_until_pos(20, 10, "midreset_pre");
    step(1'b1, 1'b0, 1'b0, 1'b0, "midreset");
    relock("midreset_relock");

    // V fall coinciding with H fall on every frame.
    run_until_pos(0, 0, "simul_pre");
    vfx = HS;
    step(1'b1, 1'b0, 1'b0, 1'b0, "simul_reset");
    relock("simul_lock");
    run_until_vfall(1'b1, 1'b1, 1'b0, "simul_frame");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/receptor_vga_sincronia.md
# receptor_vga_sincronia

Recovers pixel coordinates and timing lock from a 640x480@60 VGA sync stream with active-low H_SYNC/V_SYNC, one pixel per clk25 cycle. It is the receiving end of the sync interface that controladorVGA drives. It re-derives cuentaX/cuentaY, a visible-area flag and a frame strobe from the syncs alone, and flags timing violations. Uses: loopback self-check of the VGA chain, and driving capture/overlay logic from an external sync source.

## Interface
- H_TOTAL, 800, clocks per line
- H_VISIBLE, 640, visible pixels per line
- H_SYNC_INICIO, 656, X coordinate of the H_SYNC falling edge
- V_TOTAL, 525, lines per frame
- V_VISIBLE, 480, visible lines per frame
- V_SYNC_INICIO, 490, Y coordinate of the V_SYNC falling edge
- clk25  in  1  pixel clock; the only clock
- botonRST  in  1  synchronous, active-high reset
- H_SYNC  in  1  horizontal sync, active low, synchronous to clk25
- V_SYNC  in  1  vertical sync, active low, synchronous to clk25
- cuentaX  out  10  recovered X, 0..H_TOTAL-1
- cuentaY  out  10  recovered Y, 0..V_TOTAL-1
- visible  out  1  cuentaX<H_VISIBLE and cuentaY<V_VISIBLE and enganchado
- enganchado  out  1  timing lock achieved
- cuadroNuevo  out  1  one-cycle strobe on each V_SYNC fall while locked
- errorSincronia  out  1  one-cycle pulse when lock is lost

## Operation
- Input stage: h_q and v_q register H_SYNC and V_SYNC. A falling edge is H_SYNC==0 && h_q==1 (same rule for V). Edges are evaluated and acted on at the same clock edge.
- X counter: on an H fall, load H_SYNC_INICIO. Otherwise it wraps H_TOTAL-1 → 0, else increments.
- Y counter: on a V fall, load V_SYNC_INICIO. A V fall has priority over the X-wrap increment. Otherwise, on an X wrap, Y wraps V_TOTAL-1 → 0, else increments.
- periodo (10 b, saturates at 1023): loads 1 on an H fall, else increments. At an H fall, the pre-load value is the line length.
- lineas (10 b, saturates at 1023): counts H falls since the last V fall. Cleared to 0 on a V fall; a simultaneous H fall counts into the new frame, giving 1.
- malo flag: set when a checked line length != H_TOTAL.
- FSM states are BUSCANDO, MIDIENDO and ENGANCHADO.
  - BUSCANDO: on a V fall → MIDIENDO; clear malo; set primera.
  - MIDIENDO: on each H fall, check periodo, except the first H fall after entry (primera cleared, no check).
  - MIDIENDO: on a V fall, if lineas==V_TOTAL and !malo → ENGANCHADO. Otherwise stay in MIDIENDO, clear malo, set primera.
  - MIDIENDO: periodo==1023 or lineas==1023 → BUSCANDO, with no error pulse.
  - ENGANCHADO: any of the following → BUSCANDO with errorSincronia=1 for one cycle:
    - an H fall with periodo != H_TOTAL
    - a V fall with lineas != V_TOTAL
    - periodo==1023 or lineas==1023 (loss of signal)
  - ENGANCHADO: a V fall with correct lineas → cuadroNuevo=1 for one cycle.
- Counters free-run in every state. cuentaX/cuentaY are meaningful only while enganchado=1.
- Arithmetic: all counters are 10-bit unsigned, with no wrap past their saturate or total limits.

## Timing
- Reset values: cuentaX=0, cuentaY=0, periodo=0, lineas=0, h_q=1, v_q=1 (no spurious edge after reset). FSM=BUSCANDO; visible, enganchado, cuadroNuevo and errorSincronia are all 0.
- Reset mid-frame aborts lock immediately. Relock then needs one full measured frame: first V fall → MIDIENDO, second V fall → ENGANCHADO.
- Latency: cuentaX/cuentaY describe the sync sample held in h_q/v_q, i.e. 1 cycle after the pin. The cycle where h_q first reads 0 shows cuentaX=656.
- enganchado rises at the same edge that loads cuentaY=490 on the second valid V fall.
- errorSincronia and the enganchado fall occur at the offending edge.
- visible is combinational from the registered counters and the state.

## Test plan
- Nominal: a controladorVGA-equivalent stream from reset → enganchado=1 at the 2nd V fall. In that cycle, cuentaY=490 and cuadroNuevo=1. The h_q fall cycle shows cuentaX=656. visible is high for exactly 640x480 cycles per frame.
- Long line: locked, one line of 801 clocks → errorSincronia pulses once at that H fall, enganchado=0. Relock after 2 further V falls.
- Short frame: locked, a frame of 524 lines → error pulse at the V fall, no cuadroNuevo.
- Loss of signal: locked, H_SYNC held high → error pulse when periodo reaches 1023, i.e. 1022 cycles after the last H fall.
- Simultaneous events: V fall on the same edge as the X 799→0 wrap → cuentaY=490, not an increment. V fall coinciding with an H fall → lineas=1 afterwards.
- Reset mid-frame: assert botonRST at X=300, Y=200 while locked → next cycle all outputs 0, FSM=BUSCANDO. A nominal stream relocks at the 2nd V fall.
